fifo_flex: RTL and testbench

Parametrised single-clock synchronous FIFO; the next generation of the team's basic FIFO.
- Adds: arbitrary (non-power-of-2) depth, selectable standard or first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, occupancy count output, synchronous flush, sticky overflow/underflow error flags.
- Sits between producer/consumer blocks in one clock domain, e.g. ingress buffering ahead of a packet parser.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 27 ++
 rtl/fifo_flex.sv | 164 ++++++++++++++++
 tb/tb_fifo_flex.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_flex family.
// Read-mode selectors, count width sizing, and pointer wrap for arbitrary depths.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Purpose: simple dual-port register array, one synchronous write port, one async read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the wrapper gates the write enable.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_flex.sv
// Purpose: single-clock FIFO, any depth, standard or FWFT read, thresholds, count, sticky errors.
// Latency: standard read 1 cycle after rd_en; FWFT head visible the cycle after write/pop.
// Backpressure: full rejects writes unless a read is accepted the same cycle; errors are sticky.
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = FIFO_STD,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                          clk,
    input  logic                          rst_,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          dout_valid,
    output logic                          full,
    output logic                          almost_full,
    output logic                          empty,
    output logic                          almost_empty,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic full_q, full_d, almost_full_q, almost_full_d;
    logic empty_q, empty_d, almost_empty_q, almost_empty_d;
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    logic rd_acc, wr_acc, rd_pop, wr_push;
    logic [DATA_WIDTH-1:0] mem_rdata;

    always_comb begin
        rd_acc  = rd_en & ~empty_q;
        wr_acc  = wr_en & (~full_q | rd_acc);
        // Flush masks both requests so nothing moves and no error is flagged.
        rd_pop  = rd_acc & ~flush;
        wr_push = wr_acc & ~flush;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_push) begin
                wr_ptr_d = PTR_W'(ptr_inc(int'(wr_ptr_q), DEPTH));
            end
            if (rd_pop) begin
                rd_ptr_d = PTR_W'(ptr_inc(int'(rd_ptr_q), DEPTH));
            end
            count_d = count_q + CNT_W'(wr_push) - CNT_W'(rd_pop);
            if (wr_en & ~wr_acc) begin
                overflow_d = 1'b1;
            end
            if (rd_en & ~rd_acc) begin
                underflow_d = 1'b1;
            end
        end

        full_d         = (count_d == DEPTH_C);
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= AF_C);
        almost_empty_d = (count_d <= AE_C);
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_push),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            // Drive zero while empty so the unreset array never leaks onto dout.
            assign dout       = empty_q ? '0 : mem_rdata;
            assign dout_valid = ~empty_q;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q, dout_d;
            logic                  dout_valid_q, dout_valid_d;

            always_comb begin
                dout_d       = dout_q;
                dout_valid_d = rd_pop;
                if (rd_pop) begin
                    dout_d = mem_rdata;
                end
            end

            always_ff @(posedge clk or posedge rst_) begin
                if (rst_) begin
                    dout_q       <= '0;
                    dout_valid_q <= 1'b0;
                end else begin
                    dout_q       <= dout_d;
                    dout_valid_q <= dout_valid_d;
                end
            end

            assign dout       = dout_q;
            assign dout_valid = dout_valid_q;
        end
    endgenerate

    assign count        = count_q;
    assign full         = full_q;
    assign almost_full  = almost_full_q;
    assign empty        = empty_q;
    assign almost_empty = almost_empty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex: depth-16 standard, depth-5 standard, depth-4 FWFT instances.
module tb_fifo_flex;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: DEPTH=16, standard read
    logic       a_flush, a_wr, a_rd;
    logic [7:0] a_din, a_dout;
    logic       a_dv, a_full, a_af, a_empty, a_ae, a_ovf, a_udf;
    logic [4:0] a_count;

    // Instance B: DEPTH=5, standard read, AF=3, AE=2
    logic       b_flush, b_wr, b_rd;
    logic [7:0] b_din, b_dout;
    logic       b_dv, b_full, b_af, b_empty, b_ae, b_ovf, b_udf;
    logic [2:0] b_count;

    // Instance F: DEPTH=4, FWFT
    logic       f_flush, f_wr, f_rd;
    logic [7:0] f_din, f_dout;
    logic       f_dv, f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
    logic [2:0] f_count;

    fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_a (
        .clk(clk), .rst_(rst_), .flush(a_flush), .wr_en(a_wr), .din(a_din), .rd_en(a_rd),
        .dout(a_dout), .dout_valid(a_dv), .full(a_full), .almost_full(a_af), .empty(a_empty),
        .almost_empty(a_ae), .count(a_count), .overflow(a_ovf), .underflow(a_udf)
    );

    fifo_flex #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0), .AF_THRESH(3), .AE_THRESH(2)) u_b (
        .clk(clk), .rst_(rst_), .flush(b_flush), .wr_en(b_wr), .din(b_din), .rd_en(b_rd),
        .dout(b_dout), .dout_valid(b_dv), .full(b_full), .almost_full(b_af), .empty(b_empty),
        .almost_empty(b_ae), .count(b_count), .overflow(b_ovf), .underflow(b_udf)
    );

    fifo_flex #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1)) u_f (
        .clk(clk), .rst_(rst_), .flush(f_flush), .wr_en(f_wr), .din(f_din), .rd_en(f_rd),
        .dout(f_dout), .dout_valid(f_dv), .full(f_full), .almost_full(f_af), .empty(f_empty),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ = 1'b1;
        a_flush = 0; a_wr = 0; a_rd = 0; a_din = '0;
        b_flush = 0; b_wr = 0; b_rd = 0; b_din = '0;
        f_flush = 0; f_wr = 0; f_rd = 0; f_din = '0;

        // Reset state, before any clock edge
        #2;
        chk("rst_count", 32'(a_count), 0);
        chk("rst_flags {full,af,empty,ae,ovf,udf,dv}",
            32'({a_full, a_af, a_empty, a_ae, a_ovf, a_udf, a_dv}), 32'b0011000);
        chk("rst_dout", 32'(a_dout), 0);
        chk("rst_fwft_dv", 32'(f_dv), 0);
        chk("rst_fwft_dout", 32'(f_dout), 0);
        #10 rst_ = 1'b0;

        // A: fill 16 words
        for (int i = 1; i <= 16; i++) begin
            a_wr = 1; a_din = 8'(i);
            tick();
            chk("fill_count", 32'(a_count), 32'(i));
            chk("fill_af", 32'(a_af), 32'(i >= 14));
            chk("fill_full", 32'(a_full), 32'(i == 16));
        end
        a_wr = 0;

        // A: drain 16 words, 1-cycle latency
        for (int i = 1; i <= 16; i++) begin
            a_rd = 1;
            tick();
            chk("drain_dout", 32'(a_dout), 32'(i));
            chk("drain_dv", 32'(a_dv), 1);
            chk("drain_count", 32'(a_count), 32'(16 - i));
        end
        a_rd = 0;
        tick();
        chk("idle_dv", 32'(a_dv), 0);
        chk("idle_dout_hold", 32'(a_dout), 32'h10);
        chk("idle_empty", 32'(a_empty), 1);
        chk("idle_udf", 32'(a_udf), 0);

        // A: refill, then simultaneous read/write while full
        for (int i = 0; i < 16; i++) begin
            a_wr = 1; a_din = 8'(32'h20 + i);
            tick();
        end
        chk("refill_full", 32'(a_full), 1);
        for (int k = 0; k < 3; k++) begin
            a_wr = 1; a_rd = 1; a_din = 8'(32'h40 + k);
            tick();
            chk("rw_full_dout", 32'(a_dout), 32'(32'h20 + k));
            chk("rw_full_count", 32'(a_count), 16);
            chk("rw_full_ovf", 32'(a_ovf), 0);
        end
        a_rd = 0; a_din = 8'h99;
        tick();
        chk("ovf_set", 32'(a_ovf), 1);
        chk("ovf_count", 32'(a_count), 16);
        a_wr = 0;
        tick();
        chk("ovf_sticky", 32'(a_ovf), 1);

        // A: flush, then underflow cases
        a_flush = 1;
        tick();
        a_flush = 0;
        chk("flush_count", 32'(a_count), 0);
        chk("flush_empty", 32'(a_empty), 1);
        chk("flush_ovf", 32'(a_ovf), 0);
        chk("flush_dout_hold", 32'(a_dout), 32'h22);
        chk("flush_dv", 32'(a_dv), 0);
        a_rd = 1;
        tick();
        chk("udf_set", 32'(a_udf), 1);
        chk("udf_dout_hold", 32'(a_dout), 32'h22);
        chk("udf_dv", 32'(a_dv), 0);
        a_wr = 1; a_din = 8'h55;
        tick();
        chk("empty_rw_count", 32'(a_count), 1);
        chk("empty_rw_udf", 32'(a_udf), 1);
        a_wr = 0;
        tick();
        chk("empty_rw_data", 32'(a_dout), 32'h55);
        chk("empty_rw_count0", 32'(a_count), 0);
        a_rd = 0;

        // A: 7 entries, then flush with a concurrent write
        for (int i = 0; i < 7; i++) begin
            a_wr = 1; a_din = 8'(32'h60 + i);
            tick();
        end
        chk("load7_count", 32'(a_count), 7);
        a_flush = 1; a_din = 8'hEE;
        tick();
        a_flush = 0;
        chk("flushwr_count", 32'(a_count), 0);
        chk("flushwr_empty_ae", 32'({a_empty, a_ae}), 32'b11);
        chk("flushwr_errs", 32'({a_ovf, a_udf}), 0);
        a_din = 8'h77;
        tick();
        a_wr = 0; a_rd = 1;
        tick();
        a_rd = 0;
        chk("flushwr_discard", 32'(a_dout), 32'h77);

        // A: asynchronous reset mid-burst
        a_wr = 1; a_din = 8'hC1;
        tick();
        a_din = 8'hC2;
        tick();
        chk("burst_count", 32'(a_count), 2);
        #2 rst_ = 1'b1;
        #1;
        chk("arst_count", 32'(a_count), 0);
        chk("arst_flags {full,af,empty,ae,ovf,udf,dv}",
            32'({a_full, a_af, a_empty, a_ae, a_ovf, a_udf, a_dv}), 32'b0011000);
        chk("arst_dout", 32'(a_dout), 0);
        a_wr = 0;
        #2 rst_ = 1'b0;
        a_wr = 1; a_din = 8'hD1;
        tick();
        a_wr = 0; a_rd = 1;
        tick();
        a_rd = 0;
        chk("post_rst_data", 32'(a_dout), 32'hD1);

        // B: depth 5, 12 words through two pointer wraps
        for (int i = 1; i <= 5; i++) begin
            b_wr = 1; b_din = 8'(32'hA0 + i - 1);
            tick();
            chk("b_fill_count", 32'(b_count), 32'(i));
            chk("b_fill_af", 32'(b_af), 32'(i >= 3));
            chk("b_fill_ae", 32'(b_ae), 32'(i <= 2));
            chk("b_fill_full", 32'(b_full), 32'(i == 5));
        end
        for (int k = 5; k < 12; k++) begin
            b_wr = 1; b_rd = 1; b_din = 8'(32'hA0 + k);
            tick();
            chk("b_rw_dout", 32'(b_dout), 32'(32'hA0 + k - 5));
            chk("b_rw_count", 32'(b_count), 5);
        end
        b_wr = 0;
        for (int k = 7; k < 12; k++) begin
            b_rd = 1;
            tick();
            chk("b_drain_dout", 32'(b_dout), 32'(32'hA0 + k));
            chk("b_drain_count", 32'(b_count), 32'(11 - k));
        end
        b_rd = 0;
        tick();
        chk("b_empty", 32'(b_empty), 1);
        chk("b_errs", 32'({b_ovf, b_udf}), 0);

        // F: first-word-fall-through
        f_wr = 1; f_din = 8'h3C;
        tick();
        chk("f_dout", 32'(f_dout), 32'h3C);
        chk("f_dv", 32'(f_dv), 1);
        f_din = 8'h3D;
        tick();
        f_wr = 0;
        chk("f_head_hold", 32'(f_dout), 32'h3C);
        chk("f_count2", 32'(f_count), 2);
        f_rd = 1;
        tick();
        chk("f_pop1_dout", 32'(f_dout), 32'h3D);
        chk("f_pop1_dv", 32'(f_dv), 1);
        tick();
        f_rd = 0;
        chk("f_pop2_dv", 32'(f_dv), 0);
        chk("f_pop2_empty", 32'(f_empty), 1);
        chk("f_udf", 32'(f_udf), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
